// File: rtl/sound_dac.sv
// Sigma-delta audio output stage with pop-free start-up and mute ramps around mid-scale.
// Level slews 1 LSB per ramp step outside PLAY; in PLAY it tracks the captured sample each tick.
module sound_dac #(
    parameter int CLK_DIV    = 4,
    parameter int RAMP_SHIFT = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    input  logic       mute,
    output logic       audio_out,
    output logic       ready,
    output logic [7:0] level
);

    localparam int         DIVW = $clog2(CLK_DIV);
    localparam logic [7:0] MID  = 8'h80;

    typedef enum logic [2:0] {
        ST_START,
        ST_MUTE,
        ST_RAMP_UP,
        ST_PLAY,
        ST_RAMP_DOWN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_hold;
    logic [7:0]            r_acc;
    logic [7:0]            r_level;
    logic [7:0]            w_level_nxt;
    logic [DIVW-1:0]       r_div;
    logic [RAMP_SHIFT-1:0] r_ramp;
    logic                  r_audio;
    logic                  r_ready;
    logic                  w_tick;
    logic                  w_step;
    logic [8:0]            w_sum;
    logic [7:0]            w_toward_hold;
    logic [7:0]            w_toward_mid;

    assign w_tick = (r_div == DIVW'(CLK_DIV - 1));
    assign w_step = w_tick && (&r_ramp);
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_level};

    // Single-LSB slews; the hold target is live so a mid-ramp capture retargets the next step.
    assign w_toward_hold = (r_hold > r_level) ? r_level + 8'd1 :
                           (r_hold < r_level) ? r_level - 8'd1 : r_level;
    assign w_toward_mid  = (MID > r_level) ? r_level + 8'd1 :
                           (MID < r_level) ? r_level - 8'd1 : r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_step) begin
            case (r_state)
                ST_START:     if (r_level + 8'd1 == MID) w_state_nxt = mute ? ST_MUTE : ST_RAMP_UP;
                ST_MUTE:      if (!mute) w_state_nxt = ST_RAMP_UP;
                ST_RAMP_UP: begin
                    if (mute)                         w_state_nxt = ST_RAMP_DOWN;
                    else if (w_toward_hold == r_hold) w_state_nxt = ST_PLAY;
                end
                ST_PLAY:      if (mute) w_state_nxt = ST_RAMP_DOWN;
                ST_RAMP_DOWN: begin
                    if (!mute)                    w_state_nxt = ST_RAMP_UP;
                    else if (w_toward_mid == MID) w_state_nxt = ST_MUTE;
                end
                default:      w_state_nxt = ST_START;
            endcase
        end
    end

    // A mute/unmute reversal on a step changes direction without moving the level.
    always_comb begin
        w_level_nxt = r_level;
        if (w_tick) begin
            case (r_state)
                ST_START:     if (w_step) w_level_nxt = r_level + 8'd1;
                ST_RAMP_UP:   if (w_step && !mute) w_level_nxt = w_toward_hold;
                ST_PLAY:      w_level_nxt = r_hold;
                ST_RAMP_DOWN: if (w_step && mute) w_level_nxt = w_toward_mid;
                default:      w_level_nxt = r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold  <= MID;
            r_acc   <= 8'h00;
            r_div   <= '0;
            r_ramp  <= '0;
            r_level <= 8'h00;
            r_audio <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            if (sample_valid) begin
                r_hold <= sample;
            end
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_ready <= (w_state_nxt == ST_MUTE) || (w_state_nxt == ST_PLAY);
            if (w_tick) begin
                r_ramp  <= r_ramp + 1'b1;
                r_acc   <= w_sum[7:0];
                r_audio <= w_sum[8];
                r_level <= w_level_nxt;
            end
        end
    end

    assign audio_out = r_audio;
    assign ready     = r_ready;
    assign level     = r_level;

endmodule

// File: tb/tb_sound_dac.sv
// Scoreboard bench for sound_dac: a tick-level behavioural model queues expected outputs,
// a negedge monitor pops and compares them; directed checks cover timing and duty cycles.
module tb_sound_dac;

    localparam int CLK_DIV    = 4;
    localparam int RAMP_SHIFT = 2;
    localparam int RPERIOD    = 1 << RAMP_SHIFT;

    localparam int S_START = 0;
    localparam int S_MUTE  = 1;
    localparam int S_UP    = 2;
    localparam int S_PLAY  = 3;
    localparam int S_DOWN  = 4;

    typedef struct {
        int lvl;
        int out;
        int rdy;
    } expect_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sample = 8'h80;
    logic       sample_valid = 1'b0;
    logic       mute = 1'b1;
    logic       audio_out;
    logic       ready;
    logic [7:0] level;

    int nCompared = 0;
    int nMismatched = 0;

    expect_t expQ[$];
    int      mLevel, mAcc, mHold, mSt, mCyc, mTicks, mOut;
    bit      lastTick;

    sound_dac #(.CLK_DIV(CLK_DIV), .RAMP_SHIFT(RAMP_SHIFT)) dut (
        .clk(clk),
        .reset(reset),
        .sample(sample),
        .sample_valid(sample_valid),
        .mute(mute),
        .audio_out(audio_out),
        .ready(ready),
        .level(level)
    );

    always #5 clk = ~clk;

    // Reference model: one evaluation per modulator tick, written from the behavioural rules.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mLevel = 0; mAcc = 0; mHold = 128; mSt = S_START;
            mCyc = 0; mTicks = 0; mOut = 0; lastTick = 0;
            expQ.delete();
        end else begin
            bit isStep;
            int sum;
            expect_t e;
            mCyc++;
            lastTick = (mCyc % CLK_DIV) == 0;
            if (lastTick) begin
                mTicks++;
                isStep = (mTicks % RPERIOD) == 0;
                sum = mAcc + mLevel;
                mOut = sum / 256;
                mAcc = sum % 256;
                case (mSt)
                    S_START: if (isStep) begin
                        mLevel++;
                        if (mLevel == 128) mSt = mute ? S_MUTE : S_UP;
                    end
                    S_MUTE: if (isStep && !mute) mSt = S_UP;
                    S_UP: if (isStep) begin
                        if (mute) mSt = S_DOWN;
                        else begin
                            if (mLevel < mHold) mLevel++;
                            else if (mLevel > mHold) mLevel--;
                            if (mLevel == mHold) mSt = S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        mLevel = mHold;
                        if (isStep && mute) mSt = S_DOWN;
                    end
                    default: if (isStep) begin
                        if (!mute) mSt = S_UP;
                        else begin
                            if (mLevel < 128) mLevel++;
                            else if (mLevel > 128) mLevel--;
                            if (mLevel == 128) mSt = S_MUTE;
                        end
                    end
                endcase
                e.lvl = mLevel;
                e.out = mOut;
                e.rdy = (mSt == S_MUTE || mSt == S_PLAY) ? 1 : 0;
                expQ.push_back(e);
            end
            if (sample_valid) mHold = sample;
        end
    end

    always @(negedge clk) begin
        if (reset && expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            nCompared++;
            if (int'(level) != e.lvl || int'(audio_out) != e.out || int'(ready) != e.rdy) begin
                nMismatched++;
                $display("[TB] FAIL tickOutput @%0t: got level=%02h out=%0b ready=%0b, want level=%02h out=%0d ready=%0d",
                         $time, level, audio_out, ready, e.lvl, e.out, e.rdy);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s @%0t: got %0d (0x%0h), want %0d (0x%0h)", name, $time, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s, input logic v, input logic m);
        @(negedge clk);
        sample       = s;
        sample_valid = v;
        mute         = m;
    endtask

    // mode 0 waits for ready==want, mode 1 waits for level==want
    task automatic waitUntil(input string name, input int mode, input int want, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mode == 0 && int'(ready) == want) break;
            if (mode == 1 && int'(level) == want) break;
        end
        nCompared++;
        if (i == budget) begin
            nMismatched++;
            $display("[TB] FAIL %s timeout @%0t: ready=%0b level=%02h, want %0d", name, $time, ready, level, want);
        end
    endtask

    task automatic countOnes(input int nTicks, output int ones);
        int seen;
        seen = 0;
        ones = 0;
        while (seen < nTicks) begin
            @(negedge clk);
            if (lastTick) begin
                ones += int'(audio_out);
                seen++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ones;
        int dummy;
        logic [7:0] vals [3];
        int wins [3];
        logic mNow;

        #1;
        checkOutput("resetAudio", int'(audio_out), 0);
        checkOutput("resetLevel", int'(level), 0);
        checkOutput("resetReady", int'(ready), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] start-up ramp with mute held");
        repeat (15) @(posedge clk);
        #1 checkOutput("levelBeforeFirstStep", int'(level), 0);
        @(posedge clk);
        #1 checkOutput("levelFirstStep", int'(level), 1);
        repeat (2031) @(posedge clk);
        #1 checkOutput("levelEdge2047", int'(level), 8'h7F);
        checkOutput("readyEdge2047", int'(ready), 0);
        @(posedge clk);
        #1 checkOutput("levelEdge2048", int'(level), 8'h80);
        checkOutput("readyEdge2048", int'(ready), 1);
        countOnes(256, ones);
        checkOutput("midscaleOnes", ones, 128);

        $display("[TB] unmute toward 0xC0");
        applyStimulus(8'hC0, 1'b1, 1'b0);
        waitUntil("leaveMute", 0, 0, 100);
        waitUntil("reachPlay", 0, 1, 3000);
        checkOutput("levelPlayC0", int'(level), 8'hC0);
        countOnes(1, dummy);
        countOnes(256, ones);
        checkOutput("onesC0", ones, 192);

        $display("[TB] PLAY strobes");
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h40;
        wins[0] = 1024;  wins[1] = 1024;  wins[2] = 256;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(vals[k], 1'b1, 1'b0);
            applyStimulus(vals[k], 1'b0, 1'b0);
            countOnes(2, dummy);
            checkOutput("levelTracksSample", int'(level), int'(vals[k]));
            countOnes(wins[k], ones);
            checkOutput("dutyOnes", ones, (int'(vals[k]) * wins[k]) / 256);
        end

        $display("[TB] mute, then reverse mid-ramp at 0x90");
        applyStimulus(8'h40, 1'b0, 1'b1);
        waitUntil("leavePlay", 0, 0, 100);
        waitUntil("reachMute", 0, 1, 3000);
        checkOutput("levelMuted", int'(level), 8'h80);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        waitUntil("reach90", 1, 8'h90, 1000);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        repeat (RPERIOD * CLK_DIV) @(negedge clk);
        checkOutput("noStepOnReverse", int'(level), 8'h90);
        waitUntil("backToMute", 0, 1, 1000);
        checkOutput("levelBackAtMid", int'(level), 8'h80);

        $display("[TB] randomized capture and mute traffic");
        mNow = 1'b1;
        for (int it = 0; it < 80; it++) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            if ($urandom_range(0, 5) == 0) mNow = ~mNow;
            applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), mNow);
        end

        $display("[TB] async reset mid-PLAY");
        applyStimulus(8'h20, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        waitUntil("playBeforeReset", 0, 1, 8000);
        checkOutput("levelPlay20", int'(level), 8'h20);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncAudio", int'(audio_out), 0);
        checkOutput("asyncLevel", int'(level), 0);
        checkOutput("asyncReady", int'(ready), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2048) @(posedge clk);
        #1 checkOutput("restartLevel", int'(level), 8'h80);
        checkOutput("restartReady", int'(ready), 0);
        repeat (200) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sound_dac.md
# sound_dac

Audio output stage for the sound path. It consumes the 8-bit unsigned sample from the `sn76489` sound generator and drives a single PMOD pin with a first-order sigma-delta bitstream, which goes to an external RC low-pass. The stage adds pop-free start-up and mute handling: it slews the output level in 1-LSB steps to and from mid-scale (0x80), and passes samples straight through while playing.

## Interface
- `CLK_DIV`, 4: `clk` cycles per modulator tick; legal values ≥ 2.
- `RAMP_SHIFT`, 6: ramp step every 2^`RAMP_SHIFT` modulator ticks; legal values ≥ 1.

- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `sample`  in  8  unsigned sample from the sound generator; 0x80 is silence.
- `sample_valid`  in  1  capture strobe; may be tied high for continuous capture.
- `mute`  in  1  level request; 1 means ramp to and hold mid-scale.
- `audio_out`  out  1  sigma-delta bitstream to the PMOD pin.
- `ready`  out  1  high in MUTE or PLAY, low while starting or ramping.
- `level`  out  8  current modulator input level (debug).

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: `audio_out`=0, `level`=0x00, `ready`=0.
- Reset values of internal state: hold=0x80, acc=0, div counter=0, ramp counter=0, state=START.
- Capture: in any cycle with `sample_valid`=1, hold <= `sample`. Capture runs in every state.
- Tick: div counter counts 0..`CLK_DIV`-1 and wraps. `tick`=1 for the one cycle in which the counter equals `CLK_DIV`-1.
- Ramp step: ramp counter (`RAMP_SHIFT` bits) increments on each `tick` and wraps. A ramp step is a `tick` on which the ramp counter equals all-ones.
- Modulator: on each `tick`, {c, acc} <= acc + `level` (9-bit sum) and `audio_out` <= c.
  - Uses the `level` value from before any same-tick update.
  - For a constant `level` L, exactly L of every 256 consecutive ticks output 1.
  - L=0 gives constant 0. L=0xFF gives 255 of 256 ticks high.
- State machine (transitions are evaluated on ramp steps unless stated otherwise):
  - START: on each ramp step `level`+1. When `level` reaches 0x80, go to MUTE if `mute`=1, else RAMP_UP. `mute` is ignored until then.
  - MUTE: `level` held at 0x80. On a ramp step with `mute`=0, go to RAMP_UP without stepping.
  - RAMP_UP: on each ramp step, move `level` 1 LSB toward hold. When `level`==hold after the step, or already equal, go to PLAY. On a ramp step with `mute`=1, go to RAMP_DOWN instead, without stepping.
  - PLAY: on every `tick`, `level` <= hold. If `mute`=1 on a ramp step, go to RAMP_DOWN.
  - RAMP_DOWN: on each ramp step, move `level` 1 LSB toward 0x80. When `level`==0x80, go to MUTE. On a ramp step with `mute`=0, go to RAMP_UP.
- Target changes: the ramp target follows hold continuously, so a new capture mid-ramp retargets the next step. Steps are never larger than 1 LSB outside PLAY.
- `ready` is registered: 1 exactly in MUTE and PLAY.
- Reset mid-operation returns every output and all internal state to the reset values in the same cycle reset asserts, independent of `clk`.

## Timing
- First `tick` falls on the `CLK_DIV`-th rising edge after reset deasserts.
- Ramp step period: `CLK_DIV`·2^`RAMP_SHIFT` clk cycles. The first step falls at edge `CLK_DIV`·2^`RAMP_SHIFT`.
- START to 0x80 takes 128 steps. At defaults that is 128·256 = 32768 cycles (327.68 µs).
- In PLAY, a sample captured in cycle n reaches `level` on the first `tick` after n. `audio_out` reflects it one tick later.
- `audio_out` and `level` change only in `tick` cycles. `ready` and state change only in ramp-step cycles.
- Mute latency: worst case is one ramp period plus |`level`-0x80| ramp periods.

## Test plan
- Reset, `CLK_DIV`=4, `RAMP_SHIFT`=2, `mute`=1 -> `level` increments at edges 16, 32, …; `level`=0x80 and `ready`=1 at edge 2048; `audio_out` alternates 1/0 on ticks thereafter.
- In MUTE, `sample`=0xC0 held with `sample_valid`=1, then `mute`=0 -> `ready`=0 and `level` steps 0x81..0xC0 one per ramp step (64 steps); PLAY and `ready`=1 on the step reaching 0xC0; over 256 ticks exactly 192 ones.
- PLAY with `sample_valid` strobes at 0x00, 0xFF, 0x40 -> `level` tracks on the next tick each time; 256-tick high counts are 0, 255 and 64.
- RAMP_UP toward 0xFF, then assert `mute` when `level`=0x90 -> next ramp step enters RAMP_DOWN with no step; `level` decreases to 0x80; then MUTE with `ready`=1.
- Async reset asserted mid-PLAY between clk edges -> `audio_out`=0, `level`=0, `ready`=0 immediately; START sequence repeats after release.
- `level` forced to 0x00 and 0xFF in PLAY for 1024 ticks -> `audio_out` constant 0, and exactly 4 zero ticks respectively; no acc overflow artefacts.
